// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single-port data memory: core load/store (M0) vs debug/loader (M1).
// Define DMEM_ARB_PERF_CNT_EN to build the contention performance counter.
module dmem_port_arbiter #(
    parameter int unsigned AW       = 15,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,

    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,

    output logic [31:0]   contention_cnt
);

    localparam int unsigned LCW = $clog2(MAX_LOCK + 1);

    logic           last_gnt;
    logic           resp_vld;
    logic           resp_owner;
    logic [LCW-1:0] lock_cnt;
    logic [LCW-1:0] lock_cnt_nxt;
    logic           starve;
    logic           starve_nxt;
    logic           locked_gnt_c;

    // Grant selection; no grant is ever issued while reset is held.
    always_comb begin
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        locked_gnt_c = 1'b0;
        if (!reset) begin
            if (m0_req && !m1_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req && !m0_req) begin
                m1_gnt = 1'b1;
            end else if (m0_req && m1_req) begin
                if (starve) begin
                    m0_gnt = 1'b1;
                end else if (m1_lock && last_gnt) begin
                    m1_gnt       = 1'b1;
                    locked_gnt_c = 1'b1;
                end else if (last_gnt) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end
        end
    end

    // Burst-lock accounting; starve is raised as the final allowed locked grant is issued.
    always_comb begin
        lock_cnt_nxt = lock_cnt;
        starve_nxt   = starve;
        if (m0_gnt) begin
            lock_cnt_nxt = '0;
            starve_nxt   = 1'b0;
        end else begin
            if (m1_gnt) begin
                if (locked_gnt_c) begin
                    if (lock_cnt != LCW'(MAX_LOCK)) begin
                        lock_cnt_nxt = lock_cnt + LCW'(1);
                    end
                end else if (!m1_lock) begin
                    lock_cnt_nxt = '0;
                end
            end
            if (m0_req && (lock_cnt_nxt == LCW'(MAX_LOCK))) begin
                starve_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt   <= 1'b1;
            resp_vld   <= 1'b0;
            resp_owner <= 1'b0;
            lock_cnt   <= '0;
            starve     <= 1'b0;
        end else begin
            if (m0_gnt) begin
                last_gnt <= 1'b0;
            end else if (m1_gnt) begin
                last_gnt <= 1'b1;
            end
            resp_vld   <= mem_en;
            resp_owner <= m1_gnt;
            lock_cnt   <= lock_cnt_nxt;
            starve     <= starve_nxt;
        end
    end

    // Memory port mux; M0 drives address/data when idle.
    always_comb begin
        mem_en    = m0_gnt | m1_gnt;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_we    = 4'b0000;
        if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            if (m1_we) begin
                mem_we = m1_wstrb;
            end
        end else if (m0_gnt && m0_we) begin
            mem_we = m0_wstrb;
        end
    end

    assign m0_rvalid = resp_vld & ~resp_owner;
    assign m1_rvalid = resp_vld & resp_owner;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] perf_cnt;
    logic        contend_c;

    assign contend_c = (m0_req & ~m0_gnt) | (m1_req & ~m1_gnt);

    // Saturating count of cycles with at least one stalled request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt <= 32'h0;
        end else if (contend_c && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign contention_cnt = perf_cnt;
`else
    assign contention_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus queues expected grants/responses, a monitor checks them.
module tb_dmem_port_arbiter;

    localparam int unsigned AW       = 15;
    localparam int unsigned MAX_LOCK = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [31:0]   m0_wdata = '0;
    logic [3:0]    m0_wstrb = '0;
    logic          m0_gnt, m0_rvalid;
    logic [31:0]   m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [31:0]   m1_wdata = '0;
    logic [3:0]    m1_wstrb = '0;
    logic          m1_gnt, m1_rvalid;
    logic [31:0]   m1_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic [31:0]   contention_cnt;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(AW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .contention_cnt(contention_cnt)
    );

    typedef struct packed {
        logic          g0;
        logic          g1;
        logic          en;
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } gnt_exp_t;

    typedef struct packed {
        logic        owner;
        logic        chk;
        logic [31:0] data;
    } rsp_exp_t;

    gnt_exp_t gq[$];
    rsp_exp_t rq[$];
    gnt_exp_t ge, ga;
    rsp_exp_t re;
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [logic [AW-1:0]];
    logic [31:0] exp_cnt;

    // Single-port memory model with one-cycle read latency.
    always @(posedge clk) begin : mem_model
        logic [31:0] w;
        if (mem_en) begin
            w = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            mem_rdata <= w;
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            mem[mem_addr] = w;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT grants or responds.
    always @(negedge clk) begin
        if (m0_gnt || m1_gnt || mem_en) begin
            ga.g0 = m0_gnt; ga.g1 = m1_gnt; ga.en = mem_en;
            ga.we = mem_we; ga.addr = mem_addr; ga.wdata = mem_wdata;
            checks++;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL grant: unexpected g0=%b g1=%b en=%b addr=%h, required no grant",
                         m0_gnt, m1_gnt, mem_en, mem_addr);
            end else begin
                ge = gq.pop_front();
                if (ga !== ge) begin
                    errors++;
                    $display("FAIL grant @%0t: got g0=%b g1=%b en=%b we=%h addr=%h wdata=%h, required g0=%b g1=%b en=%b we=%h addr=%h wdata=%h",
                             $time, ga.g0, ga.g1, ga.en, ga.we, ga.addr, ga.wdata,
                             ge.g0, ge.g1, ge.en, ge.we, ge.addr, ge.wdata);
                end
            end
        end
        if (m0_rvalid || m1_rvalid) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rvalid: unexpected m0_rvalid=%b m1_rvalid=%b, required none", m0_rvalid, m1_rvalid);
            end else begin
                re = rq.pop_front();
                if (m0_rvalid !== !re.owner || m1_rvalid !== re.owner ||
                    (re.chk && (re.owner ? m1_rdata : m0_rdata) !== re.data)) begin
                    errors++;
                    $display("FAIL rvalid @%0t: got rv0=%b rv1=%b rdata0=%h rdata1=%h, required owner=M%0d data=%h (checked=%b)",
                             $time, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, re.owner, re.data, re.chk);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    endtask

    function automatic gnt_exp_t mk_gnt(input logic eg1);
        gnt_exp_t g;
        g.g0    = !eg1;
        g.g1    = eg1;
        g.en    = 1'b1;
        g.we    = eg1 ? (m1_we ? m1_wstrb : 4'h0) : (m0_we ? m0_wstrb : 4'h0);
        g.addr  = eg1 ? m1_addr : m0_addr;
        g.wdata = eg1 ? m1_wdata : m0_wdata;
        return g;
    endfunction

    // One cycle with the currently driven inputs; eg0/eg1 is the hand-computed winner.
    task automatic cyc(input logic eg0, input logic eg1, input logic chk, input logic [31:0] rd);
        rsp_exp_t r;
        if (eg0 || eg1) begin
            gq.push_back(mk_gnt(eg1));
            r.owner = eg1; r.chk = chk; r.data = rd;
            rq.push_back(r);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle_all();
        set_m0(1'b0, 1'b0, '0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, '0, 32'h0, 4'h0);
        m1_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] lock_pat;
        mem[15'h0010] = 32'hDEAD_BEEF;

        // Reset values, with M0 requesting to show grants are suppressed
        set_m0(1'b1, 1'b1, 15'h0123, 32'h55AA_1234, 4'hF);
        repeat (2) @(posedge clk);
        #2;
        check("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        check("rst_m1_gnt", 32'(m1_gnt), 32'h0);
        check("rst_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0000_0123);
        check("rst_mem_wdata", mem_wdata, 32'h55AA_1234);
        check("rst_contention", contention_cnt, 32'h0);
        reset = 1'b0;

        // Single master read
        set_m0(1'b1, 1'b0, 15'h0010, 32'h0, 4'h0);
        cyc(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        idle_all();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Tie after reset: M0 first, then alternate
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_m0(1'b1, 1'b0, AW'(15'h0020 + i), 32'h0, 4'h0);
            set_m1(1'b1, 1'b0, AW'(15'h0040 + i), 32'h0, 4'h0);
            cyc(i % 2 == 0, i % 2 == 1, 1'b0, 32'h0);
        end

        // Bounded lock: 4 locked M1 writes, one M0 grant, then M1 resumes
        m1_lock  = 1'b1;
        lock_pat = 7'b1101111;
        for (int i = 0; i < 7; i++) begin
            set_m0(1'b1, 1'b0, 15'h0060, 32'h0, 4'h0);
            set_m1(1'b1, 1'b1, AW'(15'h0200 + i), 32'h1111_0000 + 32'(i), 4'b0011);
            cyc(!lock_pat[i], lock_pat[i], 1'b0, 32'h0);
        end
        // Lock dropped in the same cycle M0 still requests: M0 wins
        m1_lock = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        idle_all();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Write ack to top word, then M0 reads it back while M1's ack returns
        set_m1(1'b1, 1'b1, 15'h7FFF, 32'hCAFE_F00D, 4'hF);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        set_m1(1'b0, 1'b0, '0, 32'h0, 4'h0);
        set_m0(1'b1, 1'b0, 15'h7FFF, 32'h0, 4'h0);
        cyc(1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
        idle_all();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset in the cycle after an M0 read grant: no response may appear
        set_m0(1'b1, 1'b0, 15'h0010, 32'h0, 4'h0);
        gq.push_back(mk_gnt(1'b0));
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_m0_gnt", 32'(m0_gnt), 32'h0);
        check("midrst_mem_en", 32'(mem_en), 32'h0);
        @(posedge clk);
        #2;
        check("midrst_m0_rvalid", 32'(m0_rvalid), 32'h0);
        check("midrst_m1_rvalid", 32'(m1_rvalid), 32'h0);
        check("midrst_contention", contention_cnt, 32'h0);
        idle_all();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Contention counter: 10 cycles of both masters requesting without lock
        for (int i = 0; i < 10; i++) begin
            set_m0(1'b1, 1'b0, AW'(15'h0300 + i), 32'h0, 4'h0);
            set_m1(1'b1, 1'b0, AW'(15'h0380 + i), 32'h0, 4'h0);
            cyc(i % 2 == 0, i % 2 == 1, 1'b0, 32'h0);
        end
        idle_all();
`ifdef DMEM_ARB_PERF_CNT_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        check("contention_cnt", contention_cnt, exp_cnt);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("contention_cnt_idle", contention_cnt, exp_cnt);

        check("grant_queue_drained", 32'(gq.size()), 32'h0);
        check("resp_queue_drained", 32'(rq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
